hdmi_timing_gen: RTL and testbench

HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

---
 rtl/hdmi_video_pkg.sv | 39 +++
 rtl/hdmi_line_counter.sv | 35 +++
 rtl/hdmi_timing_gen.sv | 143 ++++++++++++++
 tb/tb_hdmi_timing_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hdmi_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_video_pkg
// Purpose  : Shared video timing types, HDMI period lengths and timing presets.
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_video_pkg;

    typedef struct packed {
        logic [15:0] horiz;
        logic [15:0] hfront;
        logic [15:0] hsyncp;
        logic [15:0] hback;
        logic [15:0] vert;
        logic [15:0] vfront;
        logic [15:0] vsyncp;
        logic [15:0] vback;
    } video_timing_t;

    localparam int unsigned c_preamble_len = 8;
    localparam int unsigned c_guard_len    = 2;

    localparam video_timing_t c_timing_640x480 = '{
        16'd640, 16'd16, 16'd96,  16'd48, 16'd480, 16'd10, 16'd2, 16'd33
    };
    localparam video_timing_t c_timing_800x480 = '{
        16'd800, 16'd40, 16'd128, 16'd88, 16'd480, 16'd10, 16'd2, 16'd33
    };

    function automatic int unsigned timing_htotal(input video_timing_t t);
        return 32'(t.horiz) + 32'(t.hfront) + 32'(t.hsyncp) + 32'(t.hback);
    endfunction

    function automatic int unsigned timing_vtotal(input video_timing_t t);
        return 32'(t.vert) + 32'(t.vfront) + 32'(t.vsyncp) + 32'(t.vback);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_line_counter.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_line_counter
// Purpose  : Wrapping 0..LAST counter with hold, restart and terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_line_counter #(
    parameter int          W    = 12,
    parameter int unsigned LAST = 799
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_advance,
    input  logic         i_restart,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    localparam logic [W-1:0] c_last = W'(LAST);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset || i_restart) begin
            r_count <= '0;
        end else if (i_advance) begin
            r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/hdmi_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_timing_gen
// Purpose  : Raster timing generator with HDMI preamble and video guard flags.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_timing_gen
    import hdmi_video_pkg::*;
#(
    parameter int HORIZ  = 800,
    parameter int HFRONT = 40,
    parameter int HSYNCP = 128,
    parameter int HBACK  = 88,
    parameter int VERT   = 480,
    parameter int VFRONT = 10,
    parameter int VSYNCP = 2,
    parameter int VBACK  = 33,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1,
    parameter int CNT_W  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             resync,
    output logic             blank,
    output logic             hsync,
    output logic             vsync,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             preamble,
    output logic             video_guard
);

    localparam video_timing_t c_timing = '{
        16'(HORIZ), 16'(HFRONT), 16'(HSYNCP), 16'(HBACK),
        16'(VERT),  16'(VFRONT), 16'(VSYNCP), 16'(VBACK)
    };
    localparam int unsigned c_htotal = timing_htotal(c_timing);
    localparam int unsigned c_vtotal = timing_vtotal(c_timing);

    if (HORIZ == 0 || HFRONT == 0 || HSYNCP == 0 || HBACK == 0 ||
        VERT == 0 || VFRONT == 0 || VSYNCP == 0 || VBACK == 0 || CNT_W == 0 ||
        (HFRONT + HSYNCP + HBACK) < 12 ||
        c_htotal >= (64'd1 << CNT_W) || c_vtotal >= (64'd1 << CNT_W)) begin : g_bad_params
        $error("hdmi_timing_gen: invalid timing parameter set");
    end

    localparam logic [CNT_W-1:0] c_horiz       = CNT_W'(HORIZ);
    localparam logic [CNT_W-1:0] c_vert        = CNT_W'(VERT);
    localparam logic [CNT_W-1:0] c_vert_m1     = CNT_W'(VERT - 1);
    localparam logic [CNT_W-1:0] c_hs_start    = CNT_W'(HORIZ + HFRONT);
    localparam logic [CNT_W-1:0] c_hs_end      = CNT_W'(HORIZ + HFRONT + HSYNCP);
    localparam logic [CNT_W-1:0] c_vs_start    = CNT_W'(VERT + VFRONT);
    localparam logic [CNT_W-1:0] c_vs_end      = CNT_W'(VERT + VFRONT + VSYNCP);
    localparam logic [CNT_W-1:0] c_guard_start = CNT_W'(c_htotal - c_guard_len);
    localparam logic [CNT_W-1:0] c_pre_start   = CNT_W'(c_htotal - c_guard_len - c_preamble_len);

    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    logic             w_h_tc;
    logic             w_v_tc;
    logic             w_v_advance;

    assign w_v_advance = enable && w_h_tc;

    hdmi_line_counter #(.W(CNT_W), .LAST(c_htotal - 1)) u_hcnt (
        .clk       (clk),
        .reset     (reset),
        .i_advance (enable),
        .i_restart (resync),
        .o_count   (w_hcnt),
        .o_tc      (w_h_tc)
    );

    hdmi_line_counter #(.W(CNT_W), .LAST(c_vtotal - 1)) u_vcnt (
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_v_advance),
        .i_restart (resync),
        .o_count   (w_vcnt),
        .o_tc      (w_v_tc)
    );

    logic w_active;
    logic w_next_line_active;
    logic w_hsync_on;
    logic w_vsync_on;

    // The next line is active either after the last frame line (wrap to 0) or below VERT-1.
    assign w_active           = (w_hcnt < c_horiz) && (w_vcnt < c_vert);
    assign w_next_line_active = w_v_tc || (w_vcnt < c_vert_m1);
    assign w_hsync_on         = (w_hcnt >= c_hs_start) && (w_hcnt < c_hs_end);
    assign w_vsync_on         = (w_vcnt >= c_vs_start) && (w_vcnt < c_vs_end);

    logic             r_blank;
    logic             r_hsync;
    logic             r_vsync;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_line_start;
    logic             r_frame_start;
    logic             r_preamble;
    logic             r_video_guard;

    always_ff @(posedge clk) begin
        if (!reset || resync) begin
            r_blank       <= 1'b1;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_preamble    <= 1'b0;
            r_video_guard <= 1'b0;
        end else if (enable) begin
            r_blank       <= ~w_active;
            r_hsync       <= w_hsync_on ~^ HS_POL;
            r_vsync       <= w_vsync_on ~^ VS_POL;
            r_x           <= w_active ? w_hcnt : '0;
            r_y           <= w_active ? w_vcnt : '0;
            r_line_start  <= (w_hcnt == '0) && (w_vcnt < c_vert);
            r_frame_start <= (w_hcnt == '0) && (w_vcnt == '0);
            r_preamble    <= w_next_line_active && (w_hcnt >= c_pre_start) && (w_hcnt < c_guard_start);
            r_video_guard <= w_next_line_active && (w_hcnt >= c_guard_start);
        end
    end

    assign blank       = r_blank;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign preamble    = r_preamble;
    assign video_guard = r_video_guard;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_timing_gen
// Purpose  : Scoreboard bench for hdmi_timing_gen on a scaled-down raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_timing_gen;

    // Small raster so whole frames fit in a short run; blanking still >= 12 clocks.
    localparam int HORIZ  = 32;
    localparam int HFRONT = 4;
    localparam int HSYNCP = 6;
    localparam int HBACK  = 4;
    localparam int VERT   = 12;
    localparam int VFRONT = 2;
    localparam int VSYNCP = 2;
    localparam int VBACK  = 3;
    localparam bit HS_POL = 1'b0;
    localparam bit VS_POL = 1'b1;
    localparam int CNT_W  = 8;
    localparam int HTOTAL = HORIZ + HFRONT + HSYNCP + HBACK;
    localparam int VTOTAL = VERT + VFRONT + VSYNCP + VBACK;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             resync = 1'b0;
    logic             blank, hsync, vsync;
    logic [CNT_W-1:0] x, y;
    logic             line_start, frame_start, preamble, video_guard;

    typedef struct packed {
        logic             blank;
        logic             hsync;
        logic             vsync;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic             ls;
        logic             fs;
        logic             pre;
        logic             guard;
    } vec_t;

    vec_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   pushes      = 0;
    int   m_h         = 0;
    int   m_v         = 0;
    vec_t m_out;
    bit   counting    = 1'b0;
    int   active_seen = 0;
    int   fs_seen     = 0;

    always #5 clk = ~clk;

    hdmi_timing_gen #(
        .HORIZ(HORIZ), .HFRONT(HFRONT), .HSYNCP(HSYNCP), .HBACK(HBACK),
        .VERT(VERT), .VFRONT(VFRONT), .VSYNCP(VSYNCP), .VBACK(VBACK),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .resync(resync),
        .blank(blank), .hsync(hsync), .vsync(vsync), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start),
        .preamble(preamble), .video_guard(video_guard)
    );

    function automatic vec_t idle_vec();
        vec_t r;
        r       = '0;
        r.blank = 1'b1;
        r.hsync = !HS_POL;
        r.vsync = !VS_POL;
        return r;
    endfunction

    // What the raster rules say the outputs must be for raster position (h, v).
    function automatic vec_t pos_vec(input int h, input int v);
        vec_t r;
        bit   act;
        int   nv;
        act     = (h < HORIZ) && (v < VERT);
        nv      = (v + 1) % VTOTAL;
        r       = '0;
        r.blank = !act;
        r.hsync = (h >= HORIZ + HFRONT && h < HORIZ + HFRONT + HSYNCP) ? HS_POL : !HS_POL;
        r.vsync = (v >= VERT + VFRONT && v < VERT + VFRONT + VSYNCP) ? VS_POL : !VS_POL;
        r.x     = act ? CNT_W'(h) : '0;
        r.y     = act ? CNT_W'(v) : '0;
        r.ls    = (h == 0) && (v < VERT);
        r.fs    = (h == 0) && (v == 0);
        r.pre   = (h >= HTOTAL - 10) && (h <= HTOTAL - 3) && (nv < VERT);
        r.guard = (h >= HTOTAL - 2) && (nv < VERT);
        return r;
    endfunction

    task automatic drive(input bit rst_n, input bit rs, input bit en);
        @(negedge clk);
        reset  = rst_n;
        resync = rs;
        enable = en;
        if (!rst_n || rs) begin
            m_out = idle_vec();
            m_h   = 0;
            m_v   = 0;
        end else if (en) begin
            m_out = pos_vec(m_h, m_v);
            m_h++;
            if (m_h == HTOTAL) begin
                m_h = 0;
                m_v = (m_v + 1) % VTOTAL;
            end
        end
        exp_q.push_back(m_out);
        pushes++;
    endtask

    initial begin : monitor
        vec_t e;
        vec_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {blank, hsync, vsync, x, y, line_start, frame_start, preamble, video_guard};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL vector %0d @%0t: dut blank=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b pre=%b grd=%b, expected blank=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b pre=%b grd=%b",
                             vectors, $time, a.blank, a.hsync, a.vsync, a.x, a.y, a.ls, a.fs, a.pre, a.guard,
                             e.blank, e.hsync, e.vsync, e.x, e.y, e.ls, e.fs, e.pre, e.guard);
                end
                if (counting && !blank) active_seen++;
                if (counting && frame_start) fs_seen++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        // Two full frames of free running timing.
        counting = 1'b1;
        repeat (2 * HTOTAL * VTOTAL) drive(1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        counting = 1'b0;

        // Freeze mid-line; the first released edge must continue with x=21.
        while (!(m_h == 21 && m_v == 3)) drive(1'b1, 1'b0, 1'b1);
        repeat (50) drive(1'b1, 1'b0, 1'b0);
        repeat (5) drive(1'b1, 1'b0, 1'b1);

        // Resync together with enable=0, then release.
        while (!(m_h == 25 && m_v == 5)) drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        repeat (5) drive(1'b1, 1'b0, 1'b1);

        // Reset in the middle of the hsync pulse (active-low hsync).
        while (!(m_h == HORIZ + HFRONT + 2 && m_v == 2)) drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        repeat (5) drive(1'b1, 1'b0, 1'b1);

        repeat (4000) begin
            drive($urandom_range(0, 299) != 0, $urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0);
        end

        @(posedge clk);
        #2;

        vectors++;
        if (active_seen != 2 * HORIZ * VERT) begin
            miscompares++;
            $display("FAIL active_count: dut %0d active cycles, expected %0d", active_seen, 2 * HORIZ * VERT);
        end
        vectors++;
        if (fs_seen != 2) begin
            miscompares++;
            $display("FAIL frame_count: dut %0d frame_start pulses, expected 2", fs_seen);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, expected 0 of %0d", exp_q.size(), pushes);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
